// File: rtl/output_requant_writer.sv
// Requantizing output writer: rounds, shifts and saturates each lane of a post-ReLU
// vector and streams the packed result to the output buffer through one register stage.

module output_requant_lane #(
  parameter int OUT_WIDTH = 32,
  parameter int Q_WIDTH   = 8
) (
  input  logic [OUT_WIDTH-1:0] x_i,
  input  logic [4:0]           shift_i,
  output logic [Q_WIDTH-1:0]   q_o
);
  localparam logic signed [OUT_WIDTH:0] ONE = 1;

  logic signed [OUT_WIDTH:0] xe, rnd, y;

  // One guard bit keeps x + 2^(shift-1) from overflowing.
  always_comb begin
    xe  = {x_i[OUT_WIDTH-1], x_i};
    rnd = '0;
    y   = xe;
    if (shift_i != 5'd0) begin
      rnd = ONE << (shift_i - 5'd1);
      y   = (xe + rnd) >>> shift_i;
    end
    if (y[OUT_WIDTH])                   q_o = '0;
    else if (|y[OUT_WIDTH-1:Q_WIDTH])   q_o = '1;
    else                                q_o = y[Q_WIDTH-1:0];
  end
endmodule

module output_requant_writer #(
  parameter int ARRAY_N    = 16,
  parameter int OUT_WIDTH  = 32,
  parameter int Q_WIDTH    = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [4:0]                   shift_amt,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [ADDR_WIDTH-1:0]        num_rows,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ARRAY_N*OUT_WIDTH-1:0] data_in,
  output logic                         mem_wr_en,
  input  logic                         mem_wr_ready,
  output logic [ADDR_WIDTH-1:0]        mem_wr_addr,
  output logic [ARRAY_N*Q_WIDTH-1:0]   mem_wr_data,
  output logic                         busy,
  output logic                         done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                              state_q, state_d;
  logic [4:0]                          shift_q, shift_d;
  logic [ADDR_WIDTH-1:0]               base_q, base_d;
  logic [ADDR_WIDTH-1:0]               rows_q, rows_d;
  logic [ADDR_WIDTH-1:0]               acc_q, acc_d;
  logic [ADDR_WIDTH-1:0]               wr_cnt_q, wr_cnt_d;
  logic [ADDR_WIDTH-1:0]               addr_q, addr_d;
  logic                                wr_en_q, wr_en_d;
  logic [ARRAY_N-1:0][Q_WIDTH-1:0]     data_q, data_d, q_lane;
  logic [ARRAY_N-1:0][OUT_WIDTH-1:0]   din;
  logic                                in_xfer, wr_xfer;

  assign din = data_in;

  for (genvar i = 0; i < ARRAY_N; i++) begin : g_lane
    output_requant_lane #(.OUT_WIDTH(OUT_WIDTH), .Q_WIDTH(Q_WIDTH)) u_lane (
      .x_i     (din[i]),
      .shift_i (shift_q),
      .q_o     (q_lane[i])
    );
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    base_d   = base_q;
    rows_d   = rows_q;
    acc_d    = acc_q;
    wr_cnt_d = wr_cnt_q;
    addr_d   = addr_q;
    wr_en_d  = wr_en_q;
    data_d   = data_q;
    // The output register can reload in the same cycle it drains.
    in_ready = (state_q == RUN) && (acc_q < rows_q) && (!wr_en_q || mem_wr_ready);
    in_xfer  = in_valid && in_ready;
    wr_xfer  = wr_en_q && mem_wr_ready;
    case (state_q)
      IDLE: if (start) begin
        shift_d  = shift_amt;
        base_d   = base_addr;
        rows_d   = num_rows;
        acc_d    = '0;
        wr_cnt_d = '0;
        state_d  = (num_rows == '0) ? DONE : RUN;
      end
      RUN: begin
        if (in_xfer) begin
          acc_d   = acc_q + 1'b1;
          addr_d  = base_q + acc_q;
          data_d  = q_lane;
          wr_en_d = 1'b1;
        end else if (wr_xfer) begin
          wr_en_d = 1'b0;
        end
        if (wr_xfer) begin
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == rows_q - 1'b1) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      base_q   <= '0;
      rows_q   <= '0;
      acc_q    <= '0;
      wr_cnt_q <= '0;
      addr_q   <= '0;
      wr_en_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      base_q   <= base_d;
      rows_q   <= rows_d;
      acc_q    <= acc_d;
      wr_cnt_q <= wr_cnt_d;
      addr_q   <= addr_d;
      wr_en_q  <= wr_en_d;
      data_q   <= data_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = addr_q;
  assign mem_wr_data = data_q;
endmodule

// File: tb/tb_output_requant_writer.sv
// Randomized bench for output_requant_writer against an arithmetic reference model.

module tb_output_requant_writer;
  localparam int N = 16, OW = 32, QW = 8, AW = 10, TRL = 256;

  logic clk = 0, reset = 0, start = 0, in_valid = 0, mem_wr_ready = 0;
  logic [4:0]      shift_amt = '0;
  logic [AW-1:0]   base_addr = '0, num_rows = '0;
  logic [N*OW-1:0] data_in = '0;
  logic            in_ready, mem_wr_en, busy, done;
  logic [AW-1:0]   mem_wr_addr;
  logic [N*QW-1:0] mem_wr_data;

  int errors = 0, checks = 0;

  logic [N*OW-1:0] vecs[$];
  logic [AW-1:0]   wa[$];
  logic [N*QW-1:0] wd[$];
  int              wc[$];
  int              done_cyc, done_cnt, acc_cyc, busy_cnt, ncyc;
  logic            tr_en[TRL], tr_rdy[TRL], tr_inr[TRL];
  logic [AW-1:0]   tr_addr[TRL];
  logic [N*QW-1:0] tr_data[TRL];

  output_requant_writer #(.ARRAY_N(N), .OUT_WIDTH(OW), .Q_WIDTH(QW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .shift_amt(shift_amt), .base_addr(base_addr),
    .num_rows(num_rows), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .mem_wr_en(mem_wr_en), .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Requantization from the arithmetic definition: floor((x + d/2) / d), clamped to 0..255.
  function automatic logic [N*QW-1:0] model(input logic [N*OW-1:0] v, input int sh);
    logic [N*QW-1:0] r = '0;
    for (int i = 0; i < N; i++) begin
      longint x, y, d;
      x = longint'($signed(v[i*OW +: OW]));
      if (sh == 0) y = x;
      else begin
        d = longint'(1) << sh;
        y = x + d / 2;
        y = (y >= 0) ? y / d : -((-y + d - 1) / d);
      end
      if (y < 0) y = 0;
      else if (y > 255) y = 255;
      r[i*QW +: QW] = y[QW-1:0];
    end
    return r;
  endfunction

  function automatic logic [OW-1:0] rand_lane();
    int unsigned k = $urandom_range(0, 3);
    case (k)
      0:       return OW'($urandom());
      1:       return OW'($urandom_range(0, 8191));
      2:       return OW'(-int'($urandom_range(1, 5000)));
      default: return OW'(32'h7FFF_FFFF - $urandom_range(0, 3));
    endcase
  endfunction

  function automatic logic [N*OW-1:0] rand_vec();
    logic [N*OW-1:0] v;
    for (int i = 0; i < N; i++) v[i*OW +: OW] = rand_lane();
    return v;
  endfunction

  // Runs one job from vecs and records writes, done/busy and a per-cycle trace.
  // rdy_mode: 0 always ready, 1 random ready/valid plus a stray start, 2 stall in cycles 2..4.
  task automatic drive_job(input logic [4:0] sh, input logic [AW-1:0] base, input int rows,
                           input int rdy_mode, input int limit);
    int idx = 0;
    wa.delete(); wd.delete(); wc.delete();
    done_cyc = -1; done_cnt = 0; acc_cyc = -1; busy_cnt = 0; ncyc = 0;
    start = 1; shift_amt = sh; base_addr = base; num_rows = AW'(rows);
    in_valid = 1; data_in = rand_vec(); mem_wr_ready = 1;
    @(negedge clk);
    start = 0;
    for (int c = 1; c <= limit; c++) begin
      shift_amt = 5'($urandom()); base_addr = AW'($urandom()); num_rows = AW'($urandom());
      start = (rdy_mode == 1) && (c == 2);
      case (rdy_mode)
        0:       mem_wr_ready = 1'b1;
        1:       mem_wr_ready = 1'($urandom_range(0, 1));
        default: mem_wr_ready = !(c >= 2 && c <= 4);
      endcase
      if (idx < rows) begin
        in_valid = (rdy_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        data_in  = vecs[idx];
      end else begin
        in_valid = 1'b1;
        data_in  = rand_vec();
      end
      #1;
      if (c < TRL) begin
        tr_en[c] = mem_wr_en; tr_rdy[c] = mem_wr_ready; tr_inr[c] = in_ready;
        tr_addr[c] = mem_wr_addr; tr_data[c] = mem_wr_data;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (busy) busy_cnt++;
      if (mem_wr_en && mem_wr_ready) begin
        wa.push_back(mem_wr_addr); wd.push_back(mem_wr_data); wc.push_back(c);
      end
      if (in_valid && in_ready) begin
        if (acc_cyc < 0) acc_cyc = c;
        idx++;
      end
      ncyc = c;
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
      @(negedge clk);
    end
    start = 0; in_valid = 0; mem_wr_ready = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", mem_wr_en); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (mem_wr_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mem_wr_addr); end
    checks++; if (mem_wr_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", mem_wr_data); end
    reset = 1;
  endtask

  task automatic test_single_row();
    logic [N*OW-1:0] v;
    logic [N*QW-1:0] e = {N{8'h13}};
    for (int i = 0; i < N; i++) v[i*OW +: OW] = 32'h0000_0128;
    vecs.delete(); vecs.push_back(v);
    drive_job(5'd4, 10'h010, 1, 0, 20);
    checks++; if (wa.size() != 1) begin errors++; $display("FAIL single_count: got %0d expected 1", wa.size()); end
    if (wa.size() > 0) begin
      checks++; if (wa[0] !== 10'h010) begin errors++; $display("FAIL single_addr: got %h expected 010", wa[0]); end
      checks++; if (wd[0] !== e) begin errors++; $display("FAIL single_data: got %h expected %h", wd[0], e); end
      checks++; if (wc[0] != acc_cyc + 1) begin errors++; $display("FAIL single_latency: got %0d expected %0d", wc[0], acc_cyc + 1); end
    end
    checks++; if (done_cyc - acc_cyc != 2) begin errors++; $display("FAIL single_done_delay: got %0d expected 2", done_cyc - acc_cyc); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done_pulses: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_round_sat();
    logic [OW-1:0]   l6[6] = '{32'd5, 32'd6, 32'd1023, 32'd1024, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    int              e6[6] = '{1, 2, 255, 255, 255, 0};
    logic [N*OW-1:0] v = rand_vec();
    logic [N*QW-1:0] got;
    for (int i = 0; i < 6; i++) v[i*OW +: OW] = l6[i];
    vecs.delete(); vecs.push_back(v);
    drive_job(5'd2, 10'h100, 1, 0, 20);
    checks++; if (wa.size() != 1) begin errors++; $display("FAIL round_count: got %0d expected 1", wa.size()); end
    if (wa.size() > 0) begin
      got = wd[0];
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got[i*QW +: QW] !== QW'(e6[i])) begin
          errors++; $display("FAIL round_lane%0d: got %0d expected %0d", i, got[i*QW +: QW], e6[i]);
        end
      end
      checks++; if (got !== model(v, 2)) begin errors++; $display("FAIL round_vec: got %h expected %h", got, model(v, 2)); end
    end
  endtask

  task automatic test_backpressure();
    int stalls = 0;
    vecs.delete();
    for (int k = 0; k < 4; k++) vecs.push_back(rand_vec());
    drive_job(5'd3, 10'h040, 4, 2, 40);
    checks++; if (wa.size() != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", wa.size()); end
    for (int k = 0; k < wa.size() && k < 4; k++) begin
      checks++; if (wa[k] !== AW'(10'h040 + k)) begin errors++; $display("FAIL bp_addr%0d: got %h expected %h", k, wa[k], AW'(10'h040 + k)); end
      checks++; if (wd[k] !== model(vecs[k], 3)) begin errors++; $display("FAIL bp_data%0d: got %h expected %h", k, wd[k], model(vecs[k], 3)); end
    end
    for (int c = 1; c < ncyc && c + 1 < TRL; c++) begin
      if (tr_en[c] && !tr_rdy[c]) begin
        stalls++;
        checks++; if (tr_inr[c] !== 1'b0) begin errors++; $display("FAIL bp_in_ready_c%0d: got %b expected 0", c, tr_inr[c]); end
        checks++; if (tr_en[c+1] !== 1'b1) begin errors++; $display("FAIL bp_hold_en_c%0d: got %b expected 1", c, tr_en[c+1]); end
        checks++; if (tr_addr[c+1] !== tr_addr[c]) begin errors++; $display("FAIL bp_hold_addr_c%0d: got %h expected %h", c, tr_addr[c+1], tr_addr[c]); end
        checks++; if (tr_data[c+1] !== tr_data[c]) begin errors++; $display("FAIL bp_hold_data_c%0d: got %h expected %h", c, tr_data[c+1], tr_data[c]); end
      end
    end
    checks++; if (stalls != 3) begin errors++; $display("FAIL bp_stall_cycles: got %0d expected 3", stalls); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_pulses: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_wrap_stream();
    logic [4:0] sh = 5'($urandom_range(0, 12));
    vecs.delete();
    for (int k = 0; k < 4; k++) vecs.push_back(rand_vec());
    drive_job(sh, 10'h3FE, 4, 0, 30);
    checks++; if (wa.size() != 4) begin errors++; $display("FAIL wrap_count: got %0d expected 4", wa.size()); end
    for (int k = 0; k < wa.size() && k < 4; k++) begin
      checks++; if (wa[k] !== AW'(10'h3FE + k)) begin errors++; $display("FAIL wrap_addr%0d: got %h expected %h", k, wa[k], AW'(10'h3FE + k)); end
      checks++; if (wd[k] !== model(vecs[k], int'(sh))) begin errors++; $display("FAIL wrap_data%0d: got %h expected %h", k, wd[k], model(vecs[k], int'(sh))); end
      checks++; if (wc[k] != wc[0] + k) begin errors++; $display("FAIL wrap_stream%0d: got cycle %0d expected %0d", k, wc[k], wc[0] + k); end
    end
  endtask

  task automatic test_zero_len();
    vecs.delete();
    drive_job(5'($urandom()), AW'($urandom()), 0, 0, 10);
    checks++; if (wa.size() != 0) begin errors++; $display("FAIL zero_writes: got %0d expected 0", wa.size()); end
    checks++; if (done_cyc != 1) begin errors++; $display("FAIL zero_done_cycle: got %0d expected 1", done_cyc); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_pulses: got %0d expected 1", done_cnt); end
    checks++; if (busy_cnt != 0) begin errors++; $display("FAIL zero_busy: got %0d expected 0", busy_cnt); end
  endtask

  task automatic test_random_jobs();
    for (int j = 0; j < 6; j++) begin
      int            rows = $urandom_range(1, 12);
      logic [4:0]    sh   = 5'($urandom_range(0, 10));
      logic [AW-1:0] base = AW'($urandom());
      vecs.delete();
      for (int k = 0; k < rows; k++) vecs.push_back(rand_vec());
      drive_job(sh, base, rows, 1, 200);
      checks++; if (wa.size() != rows) begin errors++; $display("FAIL rnd%0d_count: got %0d expected %0d", j, wa.size(), rows); end
      for (int k = 0; k < wa.size() && k < rows; k++) begin
        checks++; if (wa[k] !== AW'(base + k)) begin errors++; $display("FAIL rnd%0d_addr%0d: got %h expected %h", j, k, wa[k], AW'(base + k)); end
        checks++; if (wd[k] !== model(vecs[k], int'(sh))) begin errors++; $display("FAIL rnd%0d_data%0d: got %h expected %h", j, k, wd[k], model(vecs[k], int'(sh))); end
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL rnd%0d_done_pulses: got %0d expected 1", j, done_cnt); end
    end
  endtask

  task automatic test_reset_mid();
    int idx = 0, nw = 0;
    vecs.delete();
    for (int k = 0; k < 5; k++) vecs.push_back(rand_vec());
    start = 1; shift_amt = 5'd3; base_addr = 10'h020; num_rows = 10'd5;
    in_valid = 1; data_in = vecs[0]; mem_wr_ready = 1;
    @(negedge clk);
    start = 0;
    for (int c = 1; c <= 30 && nw < 2; c++) begin
      data_in = vecs[(idx < 5) ? idx : 0];
      #1;
      if (mem_wr_en && mem_wr_ready) nw++;
      if (in_valid && in_ready) idx++;
      @(negedge clk);
    end
    checks++; if (nw != 2) begin errors++; $display("FAIL mid_writes_before_reset: got %0d expected 2", nw); end
    reset = 0;
    @(negedge clk);
    #1;
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL mid_wr_en: got %b expected 0", mem_wr_en); end
    checks++; if (mem_wr_addr !== '0) begin errors++; $display("FAIL mid_addr: got %h expected 0", mem_wr_addr); end
    checks++; if (mem_wr_data !== '0) begin errors++; $display("FAIL mid_data: got %h expected 0", mem_wr_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done: got %b expected 0", done); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready: got %b expected 0", in_ready); end
    reset = 1; in_valid = 0;
    vecs.delete();
    for (int k = 0; k < 3; k++) vecs.push_back(rand_vec());
    drive_job(5'd1, 10'h200, 3, 0, 30);
    checks++; if (wa.size() != 3) begin errors++; $display("FAIL mid_new_count: got %0d expected 3", wa.size()); end
    for (int k = 0; k < wa.size() && k < 3; k++) begin
      checks++; if (wa[k] !== AW'(10'h200 + k)) begin errors++; $display("FAIL mid_new_addr%0d: got %h expected %h", k, wa[k], AW'(10'h200 + k)); end
      checks++; if (wd[k] !== model(vecs[k], 1)) begin errors++; $display("FAIL mid_new_data%0d: got %h expected %h", k, wd[k], model(vecs[k], 1)); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL mid_new_done_pulses: got %0d expected 1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_round_sat();
    test_backpressure();
    test_wrap_stream();
    test_zero_len();
    test_random_jobs();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
